// File: rtl/pwm_bank.sv
// Multi-channel PWM generator with a register-write bus, clock prescaler,
// edge/center-aligned counting, per-channel inversion and double-buffered
// duty/mode/prescale values that are loaded into the active set at the
// period boundary (or while the bank is disabled).
`timescale 1ns/1ps
module pwm_bank #(
    parameter int N_CH   = 16,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic [N_CH-1:0]   pwm_out,
    output logic              period_start
);

    localparam logic [CNT_W-1:0] TOP = {{(CNT_W-1){1'b1}}, 1'b0};

    // Register file: CTRL, PRESCALE, and per-channel CFG/DUTY
    logic             gen_q, gen_d;
    logic             mode_sh_q, mode_sh_d, mode_act_q, mode_act_d;
    logic [CNT_W-1:0] presc_sh_q, presc_sh_d, presc_act_q, presc_act_d;
    logic [2:0]       cfg_q [N_CH];
    logic [2:0]       cfg_d [N_CH];
    logic [CNT_W-1:0] duty_sh_q [N_CH];
    logic [CNT_W-1:0] duty_sh_d [N_CH];
    logic [CNT_W-1:0] duty_act_q [N_CH];
    logic [CNT_W-1:0] duty_act_d [N_CH];

    // Timebase and outputs
    logic [CNT_W-1:0] pcnt_q, pcnt_d, cnt_q, cnt_d;
    logic             dir_q, dir_d;   // 0 = counting up, 1 = counting down
    logic             tick, wrap, load;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [N_CH-1:0]  pwm_q, pwm_d;
    logic             ps_q, ps_d;

    // Register writes from the bus; reads always see the pre-write shadow values
    always_comb begin
        gen_d      = gen_q;
        mode_sh_d  = mode_sh_q;
        presc_sh_d = presc_sh_q;
        cfg_d      = cfg_q;
        duty_sh_d  = duty_sh_q;
        rd_data_d  = '0;
        if (wr_en) begin
            if (wr_addr == ADDR_W'(0)) begin
                gen_d     = wr_data[0];
                mode_sh_d = wr_data[1];
            end
            if (wr_addr == ADDR_W'(1)) presc_sh_d = wr_data;
            for (int k = 0; k < N_CH; k++) begin
                if (int'(wr_addr) == 2 + 2 * k) cfg_d[k]     = wr_data[2:0];
                if (int'(wr_addr) == 3 + 2 * k) duty_sh_d[k] = wr_data;
            end
        end
        if (rd_addr == ADDR_W'(0)) rd_data_d = CNT_W'({mode_sh_q, gen_q});
        if (rd_addr == ADDR_W'(1)) rd_data_d = presc_sh_q;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(rd_addr) == 2 + 2 * k) rd_data_d = CNT_W'(cfg_q[k]);
            if (int'(rd_addr) == 3 + 2 * k) rd_data_d = duty_sh_q[k];
        end
    end

    // Prescaler, counter and direction; wrap marks the period boundary
    always_comb begin
        tick   = gen_q && (pcnt_q == presc_act_q);
        wrap   = 1'b0;
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        if (!gen_q) begin
            pcnt_d = '0;
            cnt_d  = '0;
            dir_d  = 1'b0;
        end else if (tick) begin
            pcnt_d = '0;
            if (!mode_act_q) begin
                if (cnt_q == TOP) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (!dir_q) begin
                if (cnt_q == TOP) begin
                    cnt_d = cnt_q - 1'b1;
                    dir_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    dir_d = 1'b0;
                    wrap  = 1'b1;
                end
            end
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
        ps_d = wrap;
    end

    // Active set follows the shadow while disabled, so enabling starts with fresh values
    always_comb begin
        load        = !gen_q || wrap;
        mode_act_d  = load ? mode_sh_q  : mode_act_q;
        presc_act_d = load ? presc_sh_q : presc_act_q;
        duty_act_d  = load ? duty_sh_q  : duty_act_q;
    end

    // Channel compare, PWM enable, inversion and output gating from pre-edge state
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            pwm_d[k] = gen_q && cfg_q[k][0] &&
                       ((cfg_q[k][1] ? (cnt_q < duty_act_q[k]) : 1'b1) ^ cfg_q[k][2]);
        end
    end

    // State update with asynchronous clear of everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_q       <= 1'b0;
            mode_sh_q   <= 1'b0;
            mode_act_q  <= 1'b0;
            presc_sh_q  <= '0;
            presc_act_q <= '0;
            pcnt_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            rd_data_q   <= '0;
            pwm_q       <= '0;
            ps_q        <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                cfg_q[k]      <= '0;
                duty_sh_q[k]  <= '0;
                duty_act_q[k] <= '0;
            end
        end else begin
            gen_q       <= gen_d;
            mode_sh_q   <= mode_sh_d;
            mode_act_q  <= mode_act_d;
            presc_sh_q  <= presc_sh_d;
            presc_act_q <= presc_act_d;
            pcnt_q      <= pcnt_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            rd_data_q   <= rd_data_d;
            pwm_q       <= pwm_d;
            ps_q        <= ps_d;
            cfg_q       <= cfg_d;
            duty_sh_q   <= duty_sh_d;
            duty_act_q  <= duty_act_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign pwm_out      = pwm_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: register access, edge/center PWM shapes, shadowing,
// address decode and asynchronous reset, checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_pwm_bank;
    localparam int N_CH = 16, CNT_W = 8, ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [CNT_W-1:0]  wr_data = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [CNT_W-1:0]  rd_data;
    logic [N_CH-1:0]   pwm_out;
    logic              period_start;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    pwm_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic void push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endfunction

    task automatic pop_chk(input logic [31:0] act);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            chk(tag_q.pop_front(), act, exp_q.pop_front());
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = CNT_W'(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic rd(input int a, input int exp, input string tag);
        @(negedge clk);
        rd_addr = ADDR_W'(a);
        push(tag, 32'(exp));
        @(posedge clk);
        #1;
        pop_chk(32'(rd_data));
    endtask

    task automatic wait_ps(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (period_start) return;
        end
        chk("period_start_timeout", 32'd0, 32'd1);
    endtask

    // Samples n cycles of one channel, optionally issuing one write at cycle wr_at
    task automatic measure(input int ch, input int n, input int wr_at, input int a, input int d,
                           output int hi, output int ps, output logic first, output logic last_ps);
        hi = 0;
        ps = 0;
        first = 1'b0;
        last_ps = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = (i == wr_at);
            wr_addr = ADDR_W'(a);
            wr_data = CNT_W'(d);
            @(posedge clk);
            #1;
            if (pwm_out[ch]) hi++;
            if (period_start) ps++;
            if (i == 0) first = pwm_out[ch];
            last_ps = period_start;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, ps;
        logic first, last_ps;

        // Writes while reset is held must have no effect
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = ADDR_W'($urandom_range(0, 35));
            wr_data = CNT_W'($urandom);
            rd_addr = ADDR_W'($urandom_range(0, 35));
            @(posedge clk);
            #1;
        end
        chk("rst_pwm_out", 32'(pwm_out), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_period_start", 32'(period_start), 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b0;
        for (int a = 0; a < 4; a++) rd(a, 0, $sformatf("rst_readback_%0d", a));

        // Edge mode: ch0 half duty, ch1 zero, ch2 full, ch3 PWM off, ch4 inverted but output off
        wr(1, 0);
        wr(2, 3);  wr(3, 8'h80);
        wr(4, 3);  wr(5, 8'h00);
        wr(6, 3);  wr(7, 8'hFF);
        wr(8, 1);  wr(9, 8'h10);
        wr(10, 6); wr(11, 8'h80);
        wr(0, 1);
        repeat (5) @(posedge clk);
        #1;
        push("edge_ch0_high", 384);  push("edge_ps_count", 3);
        measure(0, 765, -1, 0, 0, hi, ps, first, last_ps);
        pop_chk(32'(hi));            pop_chk(32'(ps));
        push("edge_duty00_high", 0);
        measure(1, 765, -1, 0, 0, hi, ps, first, last_ps);
        pop_chk(32'(hi));
        push("edge_dutyFF_high", 765);
        measure(2, 765, -1, 0, 0, hi, ps, first, last_ps);
        pop_chk(32'(hi));
        push("edge_pwm_en0_high", 765);
        measure(3, 765, -1, 0, 0, hi, ps, first, last_ps);
        pop_chk(32'(hi));
        push("edge_inv_out_off_high", 0);
        measure(4, 765, -1, 0, 0, hi, ps, first, last_ps);
        pop_chk(32'(hi));
        wait_ps(600);
        push("edge_period_ps_count", 1); push("edge_period_ps_last", 1);
        measure(0, 255, -1, 0, 0, hi, ps, first, last_ps);
        pop_chk(32'(ps));            pop_chk(32'(last_ps));

        // Shadowed duty: mid-period rewrite, then a rewrite on the boundary edge
        wait_ps(600);
        wr(3, 8'h40);
        wait_ps(600);
        rd_addr = ADDR_W'(3);
        push("shadow_mid_high", 64);
        measure(0, 255, 100, 3, 8'hC0, hi, ps, first, last_ps);
        pop_chk(32'(hi));
        push("shadow_readback", 8'hC0);
        pop_chk(32'(rd_data));
        push("shadow_next_high", 192);
        measure(0, 255, 254, 3, 8'h20, hi, ps, first, last_ps);
        pop_chk(32'(hi));
        push("boundary_write_deferred_high", 192);
        measure(0, 255, -1, 0, 0, hi, ps, first, last_ps);
        pop_chk(32'(hi));
        push("boundary_write_applied_high", 32);
        measure(0, 255, -1, 0, 0, hi, ps, first, last_ps);
        pop_chk(32'(hi));

        // Center mode, prescale 3, duty 0x10
        wr(0, 0);
        wr(3, 8'h10);
        wr(1, 3);
        wr(0, 2);
        wr(0, 3);
        wait_ps(5000);
        push("center_high", 124); push("center_ps_count", 1);
        push("center_ps_last", 1); push("center_high_at_cnt0", 1);
        measure(0, 2032, -1, 0, 0, hi, ps, first, last_ps);
        pop_chk(32'(hi));  pop_chk(32'(ps));
        pop_chk(32'(last_ps)); pop_chk(32'(first));

        // Address decode and same-cycle read/write
        wr(2 * N_CH + 2, 8'hAA);
        rd(2 * N_CH + 2, 0, "unmapped_read");
        @(negedge clk);
        wr_en = 1'b1; wr_addr = ADDR_W'(3); wr_data = 8'h55; rd_addr = ADDR_W'(3);
        push("rw_same_old", 8'h10);
        @(posedge clk);
        #1;
        pop_chk(32'(rd_data));
        @(negedge clk);
        wr_en = 1'b0;
        push("rw_same_new", 8'h55);
        @(posedge clk);
        #1;
        pop_chk(32'(rd_data));

        // Asynchronous reset mid-period
        @(posedge clk);
        #1;
        chk("pre_reset_ch2_high", 32'(pwm_out[2]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pwm_out", 32'(pwm_out), 32'd0);
        chk("async_rst_period_start", 32'(period_start), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(3, 0, "post_rst_duty");
        rd(0, 0, "post_rst_ctrl");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
